// File: rtl/button_bank_if.sv
// Bundle of raw pin inputs and conditioned outputs for button_bank.
// The conditioner uses the slave side and user logic uses the master side.
interface button_bank_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_i;
    logic [CHANNELS-1:0] btn_o;
    logic [CHANNELS-1:0] press_o;
    logic [CHANNELS-1:0] release_o;
    logic [CHANNELS-1:0] long_o;

    modport master (output btn_i, input btn_o, press_o, release_o, long_o);
    modport slave  (input btn_i, output btn_o, press_o, release_o, long_o);
endinterface

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: sync, symmetric debounce, level and press/release strobes.
// Define BTN_LONG_EN to add a per-channel long-press strobe; otherwise long_o is tied low.
module button_bank #(
    parameter int CHANNELS   = 4,
    parameter int DEB_W      = 20,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int LONG_W     = 26
) (
    input logic         clk,
    input logic         rst_n,
    button_bank_if.slave bus
);
    localparam logic [DEB_W-1:0] DEB_MAX = '1;

    if (CHANNELS < 1 || CHANNELS > 32 || DEB_W < 1 || LONG_W < 1) begin : g_badParams
        $error("button_bank: parameter out of range");
    end

    logic [CHANNELS-1:0]            raw;
    logic [CHANNELS-1:0]            syncA_q;
    logic [CHANNELS-1:0]            syncB_q;
    logic [CHANNELS-1:0]            state_q;
    logic [CHANNELS-1:0]            state_d;
    logic [CHANNELS-1:0]            press_q;
    logic [CHANNELS-1:0]            release_q;
    logic [CHANNELS-1:0][DEB_W-1:0] ctr_q;
    logic [CHANNELS-1:0][DEB_W-1:0] ctr_d;

    assign raw = bus.btn_i ^ {CHANNELS{ACTIVE_LOW}};

    // A single cycle of agreement with the current state restarts the count.
    always_comb begin
        state_d = state_q;
        ctr_d   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (syncB_q[i] != state_q[i]) begin
                if (ctr_q[i] == DEB_MAX) begin
                    state_d[i] = syncB_q[i];
                end else begin
                    ctr_d[i] = ctr_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA_q   <= '0;
            syncB_q   <= '0;
            state_q   <= '0;
            ctr_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            syncA_q   <= raw;
            syncB_q   <= syncA_q;
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            press_q   <= state_d & ~state_q;
            release_q <= ~state_d & state_q;
        end
    end

    assign bus.btn_o     = state_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;

`ifdef BTN_LONG_EN
    localparam logic [LONG_W-1:0] LONG_MAX = '1;

    logic [CHANNELS-1:0][LONG_W-1:0] lctr_q;
    logic [CHANNELS-1:0][LONG_W-1:0] lctr_d;
    logic [CHANNELS-1:0]             long_q;
    logic [CHANNELS-1:0]             long_d;

    // The strobe fires only on the step into saturation, so once per press.
    always_comb begin
        lctr_d = '0;
        long_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q[i]) begin
                if (lctr_q[i] != LONG_MAX) begin
                    lctr_d[i] = lctr_q[i] + 1'b1;
                    long_d[i] = (lctr_d[i] == LONG_MAX);
                end else begin
                    lctr_d[i] = lctr_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lctr_q <= '0;
            long_q <= '0;
        end else begin
            lctr_q <= lctr_d;
            long_q <= long_d;
        end
    end

    assign bus.long_o = long_q;
`else
    assign bus.long_o = '0;
`endif
endmodule
